// File: rtl/aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_seq
// Purpose  : AES round/sub-round sequencer with reverse key-schedule phase
//            for decryption. Optional macro AES_ROUND_SEQ_ABORT_EN enables
//            the abort input.
// Revision : 1.0
// ============================================================================
module aes_round_seq #(
    parameter int SUB_ROUNDS = 16,
    parameter int SR_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            enc_dec,
    input  logic [1:0]      mode,
    input  logic            abort,
    output logic            busy,
    output logic [3:0]      round,
    output logic [SR_W-1:0] sub_round,
    output logic            round_start,
    output logic            round_complete,
    output logic            key_gen,
    output logic [3:0]      key_gen_round,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        ROUND  = 2'd2
    } state_t;

    localparam logic [SR_W-1:0] SR_LAST = SR_W'(SUB_ROUNDS - 1);

    state_t     state;
    logic [1:0] mode_q;
    logic [3:0] nr;
    logic       last_slice;
    logic       abort_hit;

    // Round count comes from the mode captured at accept, never the live port.
    always_comb begin
        nr = 4'd14;
        case (mode_q)
            2'b00:   nr = 4'd10;
            2'b01:   nr = 4'd12;
            default: nr = 4'd14;
        endcase
    end

    assign last_slice = (sub_round == SR_LAST);

`ifdef AES_ROUND_SEQ_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            state         <= IDLE;
            mode_q        <= 2'b00;
            round         <= 4'd0;
            sub_round     <= '0;
            key_gen_round <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (mode != 2'b11)) begin
                        mode_q        <= mode;
                        state         <= enc_dec ? KEYGEN : ROUND;
                        round         <= 4'd0;
                        sub_round     <= '0;
                        key_gen_round <= 4'd0;
                    end
                end
                KEYGEN: begin
                    if (key_gen_round == nr) begin
                        state         <= ROUND;
                        key_gen_round <= 4'd0;
                        round         <= 4'd0;
                        sub_round     <= '0;
                    end else begin
                        key_gen_round <= key_gen_round + 4'd1;
                    end
                end
                ROUND: begin
                    if (last_slice) begin
                        sub_round <= '0;
                        if (round == nr) begin
                            state <= IDLE;
                            round <= 4'd0;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end else begin
                        sub_round <= sub_round + SR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign key_gen        = (state == KEYGEN);
    assign round_start    = (state == ROUND) && (sub_round == '0);
    assign round_complete = (state == ROUND) && last_slice;
    // A reset or abort landing on the final slice suppresses completion.
    assign done           = round_complete && (round == nr) && !reset && !abort_hit;
    assign err            = (state == IDLE) && start && (mode == 2'b11) && !reset;

endmodule
`default_nettype wire
